// File: rtl/instruction_loader_pkg.sv
// ============================================================================
// Module  : instruction_loader_pkg
// Brief   : Shared states, widths and helpers for the boot-time program loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instruction_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    // Word index to the byte address the fetch side presents.
    function automatic logic [31:0] word_to_byte_addr(input logic [LEN_W-1:0] idx);
        return {{(32-LEN_W-IDX_W){1'b0}}, idx, {IDX_W{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_assembler.sv
// ============================================================================
// Module  : loader_word_assembler
// Brief   : Places little-endian stream bytes into 32-bit word lanes and flags
//           the byte that completes a word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module loader_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        fire,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [31:0]      lanes;
    logic [IDX_W-1:0] byte_index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes      <= '0;
            byte_index <= '0;
        end else if (clear) begin
            lanes      <= '0;
            byte_index <= '0;
        end else if (fire) begin
            lanes[{byte_index, 3'b000} +: 8] <= byte_in;
            byte_index                       <= byte_index + IDX_W'(1);
        end
    end

    // Word including the byte in flight, so the completing byte needs no extra cycle.
    always_comb begin
        word                              = lanes;
        word[{byte_index, 3'b000} +: 8]   = byte_in;
    end

    assign word_complete = fire && (byte_index == IDX_W'(WORD_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/instruction_loader.sv
// ============================================================================
// Module  : instruction_loader
// Brief   : Loads a length-prefixed byte image into instruction memory and
//           holds the core in reset until it is complete.
//           Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        writeEnable,
    output logic [31:0] writeAdress,
    output logic [31:0] writeData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpuHold
);

    localparam logic [LEN_W-1:0] SIZE_W = LEN_W'(SIZE);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_PAYLOAD_END = ST_CHECK;
`else
    localparam state_t ST_PAYLOAD_END = ST_DONE;
`endif

    state_t           state;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] word_count;
    logic [LEN_W-1:0] word_index;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    logic             w_fire;
    logic             w_start_ok;
    logic [LEN_W-1:0] w_count;
    logic [31:0]      w_word;
    logic             w_word_complete;

    assign byteReady  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                        (state == ST_DATA)   || (state == ST_CHECK);
    assign busy       = byteReady;
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);
    assign cpuHold    = (state != ST_DONE);

    assign w_fire     = byteValid && byteReady;
    assign w_start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                  (state == ST_ERROR));
    assign w_count    = {byteIn, len_lo};

    loader_word_assembler u_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (w_start_ok),
        .fire          (w_fire && (state == ST_DATA)),
        .byte_in       (byteIn),
        .word          (w_word),
        .word_complete (w_word_complete)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            len_lo      <= '0;
            word_count  <= '0;
            word_index  <= '0;
            writeEnable <= 1'b0;
            writeAdress <= '0;
            writeData   <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            writeEnable <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LEN_LO;
                        word_index <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_fire) begin
                        len_lo <= byteIn;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_fire) begin
                        word_count <= w_count;
                        if (w_count > SIZE_W)
                            state <= ST_ERROR;
                        else if (w_count == '0)
                            state <= ST_PAYLOAD_END;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire) begin
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum ^ byteIn;
`endif
                        if (w_word_complete) begin
                            writeEnable <= 1'b1;
                            writeAdress <= word_to_byte_addr(word_index);
                            writeData   <= w_word;
                            word_index  <= word_index + LEN_W'(1);
                            if (word_index == word_count - LEN_W'(1))
                                state <= ST_PAYLOAD_END;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_fire)
                        state <= (byteIn == checksum) ? ST_DONE : ST_ERROR;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that fills the instruction memory from a byte stream before the core runs. It accepts a length-prefixed stream of little-endian bytes over a valid/ready handshake and assembles 32-bit words. It issues one write per word at the byte addresses the fetch side later presents on its read address. It holds the core in reset until the image is complete, and flags overflowing or corrupted images.

## Interface

- SIZE, 128, instruction memory depth in 32-bit words; images longer than this are rejected
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load; ignored while busy
- byteIn  input  8  stream data byte
- byteValid  input  1  byteIn is valid this cycle
- byteReady  output  1  loader accepts a byte this cycle
- writeEnable  output  1  one-cycle write strobe to instruction memory
- writeAdress  output  32  byte address of the word being written, always a multiple of 4
- writeData  output  32  assembled instruction word
- busy  output  1  load in progress
- done  output  1  image loaded successfully; held until next accepted start
- error  output  1  image rejected; held until next accepted start
- cpuHold  output  1  keeps the core in reset; low only in DONE

## Operation

- Byte transfer occurs on a rising edge with byteValid && byteReady. byteReady is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 elsewhere.
- FSM states:
  - IDLE: no load in progress.
  - LEN_LO: receives the low byte of wordCount.
  - LEN_HI: receives the high byte of wordCount. wordCount is a 16-bit, little-endian word count.
  - DATA: receives payload bytes.
  - CHECK: receives the checksum byte; exists only with the macro.
  - DONE: image loaded.
  - ERROR: image rejected.
- Transitions:
  - IDLE/DONE/ERROR -> LEN_LO on start. On entry: clear done, error, wordIndex, byteIndex and checksum; set cpuHold.
  - LEN_LO -> LEN_HI on a byte transfer.
  - LEN_HI, after the byte transfer:
    - wordCount > SIZE -> ERROR.
    - wordCount == 0 -> DONE, or CHECK when checksum is built in.
    - otherwise -> DATA.
  - DATA: each transfer shifts the byte into writeData at lane byteIndex, with the first byte going to [7:0]. The 2-bit byteIndex then increments.
  - On the 4th byte (byteIndex == 3): register writeAdress = wordIndex*4, then increment wordIndex.
  - Last byte of the last word (wordIndex == wordCount-1): next state DONE, or CHECK.
- byteIndex wraps 3 -> 0. wordIndex is 16 bits and never exceeds SIZE.
- busy = 1 in LEN_LO, LEN_HI, DATA and CHECK.
- start while busy: ignored. The stream continues unaffected.
- Bytes presented in IDLE, DONE or ERROR are not accepted, since byteReady = 0.

## Timing

- Reset values: byteReady 0, writeEnable 0, writeAdress 0, writeData 0, busy 0, done 0, error 0, cpuHold 1. State is IDLE.
- Reset asserted mid-load aborts immediately to the reset values. Memory contents already written are not undone.
- writeEnable pulses high exactly one cycle, the cycle after the 4th byte of a word transfers.
  - writeAdress and writeData are stable during that cycle and hold until the next word completes.
- Byte throughput is one per cycle; writes never stall the stream.
- done, or error, rises the cycle after the final qualifying transfer. cpuHold falls in the same cycle as done rises.
- With back-to-back bytes, a load of N words finishes 2 + 4N transfers after start, plus 1 transfer with checksum.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - After the payload, the loader accepts one extra byte in CHECK.
  - It compares that byte against the XOR of all payload bytes; length bytes are excluded.
  - Match -> DONE. Mismatch -> ERROR, with cpuHold kept high.
- Undefined:
  - The CHECK state and checksum register are absent.
  - The last payload byte goes directly to DONE.

## Structure

- Shared package holds:
  - the state enum: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR;
  - WORD_BYTES = 4;
  - the 16-bit length-field width.
- One natural sub-module: loader_word_assembler, which covers byte lane shifting, byteIndex, and the word-complete flag. The FSM and address generation stay in the top.

## Test plan

- Reset mid-DATA (reset low on 3rd byte of word 1) -> all outputs return to reset values immediately. A fresh start then loads normally.
- Stream 02 00, 13 00 00 00, 93 00 10 00 -> writeEnable twice:
  - writeAdress 0x0 with writeData 0x00000013;
  - writeAdress 0x4 with writeData 0x00100093.
  - Then done=1 and cpuHold=0.
- Length 0x0081 with SIZE=128 -> error=1 the cycle after the length high byte, no writeEnable, byteReady=0 thereafter, cpuHold=1.
- Length 00 00 -> done next cycle with no writes. With LOADER_CHECKSUM_EN, a 0x00 checksum byte is required first.
- byteValid toggling every other cycle plus a start pulse during DATA -> the same words and addresses as back-to-back. The start pulse is ignored.
- LOADER_CHECKSUM_EN with a 1-word payload 13 00 00 00:
  - checksum 0x13 -> done;
  - checksum 0x12 -> error, with cpuHold held high.
